// File: rtl/dma_sram_arbiter_pkg.sv
// Shared types and default widths for the DMA copy engine that shares the SRAM with CTL.
package dma_sram_arbiter_pkg;

  localparam int DMA_ADDR_W = 16;
  localparam int DMA_DATA_W = 32;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic [1:0] {
    DMA_STATE_IDLE  = 2'd0,
    DMA_STATE_READ  = 2'd1,
    DMA_STATE_CAPT  = 2'd2,
    DMA_STATE_WRITE = 2'd3
  } dma_state_e;

  // Only READ and WRITE compete with CTL for the port; CAPT just latches read data.
  function automatic logic dma_requests(input dma_state_e st);
    return (st == DMA_STATE_READ) || (st == DMA_STATE_WRITE);
  endfunction

endpackage

// File: rtl/dma_sram_arbiter_if.sv
// CTL-side request bus, DMA control/status and the shared SRAM port.
interface dma_sram_arbiter_if
  import dma_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int LEN_W  = DMA_LEN_W
) ();

  logic [ADDR_W-1:0] cpu_ADDR;
  logic [DATA_W-1:0] cpu_DI;
  logic              cpu_EN;
  logic              cpu_WE;
  logic              dma_start;
  logic [ADDR_W-1:0] dma_src;
  logic [ADDR_W-1:0] dma_dst;
  logic [LEN_W-1:0]  dma_len;
  logic [DATA_W-1:0] sram_DO;
  logic [ADDR_W-1:0] sram_ADDR;
  logic [DATA_W-1:0] sram_DI;
  logic              sram_EN;
  logic              sram_WE;
  logic              dma_busy;
  logic              dma_done;

  modport slave (
    input  cpu_ADDR, cpu_DI, cpu_EN, cpu_WE,
    input  dma_start, dma_src, dma_dst, dma_len, sram_DO,
    output sram_ADDR, sram_DI, sram_EN, sram_WE, dma_busy, dma_done
  );

  modport master (
    output cpu_ADDR, cpu_DI, cpu_EN, cpu_WE,
    output dma_start, dma_src, dma_dst, dma_len, sram_DO,
    input  sram_ADDR, sram_DI, sram_EN, sram_WE, dma_busy, dma_done
  );

endinterface

// File: rtl/dma_sram_arbiter_mux.sv
// Combinational SRAM port mux: CTL wins outright, DMA fills idle cycles, else the port is quiet.
module dma_sram_arbiter_mux
  import dma_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_di,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_di,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_di
);

  // Port select with strict CTL priority
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = {ADDR_W{1'b0}};
    sram_di   = {DATA_W{1'b0}};
    if (cpu_en) begin
      sram_en   = 1'b1;
      sram_we   = cpu_we;
      sram_addr = cpu_addr;
      sram_di   = cpu_di;
    end else if (dma_req) begin
      sram_en   = 1'b1;
      sram_we   = dma_we;
      sram_addr = dma_addr;
      sram_di   = dma_di;
    end else begin
      sram_en   = 1'b0;
    end
  end

endmodule

// File: rtl/dma_sram_arbiter.sv
// Memory-to-memory DMA copy engine that steals SRAM cycles CTL leaves idle.
module dma_sram_arbiter
  import dma_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMA_ADDR_W,
  parameter int DATA_W = DMA_DATA_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic               clk,
  input  logic               reset,
  dma_sram_arbiter_if.slave  bus
);

  dma_state_e        state_r, state_nxt_s;
  logic [ADDR_W-1:0] src_r, src_nxt_s, dst_r, dst_nxt_s;
  logic [LEN_W-1:0]  rem_r, rem_nxt_s;
  logic [DATA_W-1:0] buf_r, buf_nxt_s;
  logic              busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic              dma_req_s, dma_we_s, dma_grant_s;
  logic [ADDR_W-1:0] dma_addr_s;

  // Request signals depend only on registered state, so the mux never loops back into the FSM.
  assign dma_req_s   = dma_requests(state_r);
  assign dma_we_s    = (state_r == DMA_STATE_WRITE);
  assign dma_addr_s  = dma_we_s ? dst_r : src_r;
  assign dma_grant_s = dma_req_s & ~bus.cpu_EN;

  assign bus.dma_busy = busy_r;
  assign bus.dma_done = done_r;

  dma_sram_arbiter_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .cpu_en    (bus.cpu_EN),
    .cpu_we    (bus.cpu_WE),
    .cpu_addr  (bus.cpu_ADDR),
    .cpu_di    (bus.cpu_DI),
    .dma_req   (dma_req_s),
    .dma_we    (dma_we_s),
    .dma_addr  (dma_addr_s),
    .dma_di    (buf_r),
    .sram_en   (bus.sram_EN),
    .sram_we   (bus.sram_WE),
    .sram_addr (bus.sram_ADDR),
    .sram_di   (bus.sram_DI)
  );

  // State and datapath registers; reset abandons any copy in flight without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= DMA_STATE_IDLE;
      src_r   <= {ADDR_W{1'b0}};
      dst_r   <= {ADDR_W{1'b0}};
      rem_r   <= {LEN_W{1'b0}};
      buf_r   <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      src_r   <= src_nxt_s;
      dst_r   <= dst_nxt_s;
      rem_r   <= rem_nxt_s;
      buf_r   <= buf_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Copy sequencer: READ -> CAPT -> WRITE per word, holding in READ/WRITE until granted
  always_comb begin
    state_nxt_s = state_r;
    src_nxt_s   = src_r;
    dst_nxt_s   = dst_r;
    rem_nxt_s   = rem_r;
    buf_nxt_s   = buf_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      DMA_STATE_IDLE: begin
        if (bus.dma_start && (bus.dma_len != {LEN_W{1'b0}})) begin
          src_nxt_s   = bus.dma_src;
          dst_nxt_s   = bus.dma_dst;
          rem_nxt_s   = bus.dma_len;
          state_nxt_s = DMA_STATE_READ;
          busy_nxt_s  = 1'b1;
        end else if (bus.dma_start) begin
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = DMA_STATE_IDLE;
        end
      end
      DMA_STATE_READ: begin
        if (dma_grant_s) begin
          state_nxt_s = DMA_STATE_CAPT;
        end else begin
          state_nxt_s = DMA_STATE_READ;
        end
      end
      DMA_STATE_CAPT: begin
        buf_nxt_s   = bus.sram_DO;
        state_nxt_s = DMA_STATE_WRITE;
      end
      DMA_STATE_WRITE: begin
        if (dma_grant_s) begin
          src_nxt_s = src_r + ADDR_W'(1);
          dst_nxt_s = dst_r + ADDR_W'(1);
          rem_nxt_s = rem_r - LEN_W'(1);
          if (rem_r == LEN_W'(1)) begin
            state_nxt_s = DMA_STATE_IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = DMA_STATE_READ;
          end
        end else begin
          state_nxt_s = DMA_STATE_WRITE;
        end
      end
      default: begin
        state_nxt_s = DMA_STATE_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

endmodule
